key_debounce: RTL and testbench

KEY_DEBOUNCE -- requirements
Module: key_debounce

---
 rtl/key_debounce.sv | 163 ++++++++++++++++
 tb/tb_key_debounce.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce.sv
// Multi-channel key debouncer: two-flop synchronizer, per-channel debounce FSM,
// press/release pulses, and an optional long-press pulse enabled by KEY_LONG_PRESS_EN.
`timescale 1ns/1ps

module key_debounce #(
  parameter int KEY_WIDTH       = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 50000000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [KEY_WIDTH-1:0] key_in,
  output logic [KEY_WIDTH-1:0] key_level,
  output logic [KEY_WIDTH-1:0] key_press,
  output logic [KEY_WIDTH-1:0] key_release,
  output logic [KEY_WIDTH-1:0] key_long
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_CNT = 2'd1,
    HELD      = 2'd2,
    REL_CNT   = 2'd3
  } state_e;

  logic [KEY_WIDTH-1:0] sync1_q;
  logic [KEY_WIDTH-1:0] sync2_q;
  logic [KEY_WIDTH-1:0] key_s;

  // Synchronizer resets to the raw "released" level so no phantom press follows reset.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= {KEY_WIDTH{ACTIVE_LOW}};
      sync2_q <= {KEY_WIDTH{ACTIVE_LOW}};
    end else begin
      sync1_q <= key_in;
      sync2_q <= sync1_q;
    end
  end

  assign key_s = ACTIVE_LOW ? ~sync2_q : sync2_q;

  for (genvar g = 0; g < KEY_WIDTH; g++) begin : g_ch
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             rel_q, rel_d;

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        level_q <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        level_q <= level_d;
        press_q <= press_d;
        rel_q   <= rel_d;
      end
    end

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      level_d = level_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
      unique case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (key_s[g]) state_d = PRESS_CNT;
        end
        PRESS_CNT: begin
          if (!key_s[g]) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = HELD;
            cnt_d   = '0;
            level_d = 1'b1;
            press_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        HELD: begin
          cnt_d = '0;
          if (!key_s[g]) state_d = REL_CNT;
        end
        REL_CNT: begin
          if (key_s[g]) begin
            state_d = HELD;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
            level_d = 1'b0;
            rel_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    assign key_level[g]   = level_q;
    assign key_press[g]   = press_q;
    assign key_release[g] = rel_q;

`ifdef KEY_LONG_PRESS_EN
    localparam int               HOLD_W    = $clog2(LONG_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              long_q, long_d;

    always_ff @(posedge clk) begin
      if (rst) begin
        hold_q <= '0;
        long_q <= 1'b0;
      end else begin
        hold_q <= hold_d;
        long_q <= long_d;
      end
    end

    // Only a fresh press restarts the hold timer; a release bounce back into HELD keeps it,
    // and saturating at LONG_CYCLES guarantees a single long pulse per press.
    always_comb begin
      hold_d = hold_q;
      long_d = 1'b0;
      if (state_q == PRESS_CNT && state_d == HELD) begin
        hold_d = '0;
      end else if (state_q == HELD || state_q == REL_CNT) begin
        if (hold_q == HOLD_LAST) long_d = 1'b1;
        if (hold_q != HOLD_MAX)  hold_d = hold_q + HOLD_ONE;
      end
    end

    assign key_long[g] = long_q;
`else
    assign key_long[g] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce: directed scenarios plus randomized key traffic,
// compared every clock against a run-length reference model of the debounce rules.
`timescale 1ns/1ps

module tb_key_debounce;

  localparam int KW   = 4;
  localparam int DEB  = 4;
  localparam int LONG = 10;
  localparam bit AL   = 1'b1;
`ifdef KEY_LONG_PRESS_EN
  localparam int LONG_EN = 1;
`else
  localparam int LONG_EN = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [KW-1:0] key_in;
  logic [KW-1:0] key_level, key_press, key_release, key_long;

  key_debounce #(
    .KEY_WIDTH      (KW),
    .DEBOUNCE_CYCLES(DEB),
    .LONG_CYCLES    (LONG),
    .ACTIVE_LOW     (AL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_in     (key_in),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: raw key delayed two samples, then a level flips once the
  // sampled pressed-state has disagreed with it for DEB+1 consecutive clocks.
  bit          d1 [KW];
  bit          d2 [KW];
  bit          lvl [KW];
  int          run [KW];
  bit          armed [KW];
  int          since [KW];
  logic [KW-1:0] e_level = '0, e_press = '0, e_rel = '0, e_long = '0;

  int n_press [KW];
  int n_rel   [KW];
  int n_long  [KW];

  task automatic model_edge();
    for (int c = 0; c < KW; c++) begin
      bit s;
      if (rst) begin
        d1[c] = AL; d2[c] = AL; lvl[c] = 1'b0; run[c] = 0;
        armed[c] = 1'b0; since[c] = 0;
        e_press[c] = 1'b0; e_rel[c] = 1'b0; e_long[c] = 1'b0;
      end else begin
        s = AL ? ~d2[c] : d2[c];
        d2[c] = d1[c];
        d1[c] = key_in[c];
        e_press[c] = 1'b0; e_rel[c] = 1'b0; e_long[c] = 1'b0;
        if (LONG_EN != 0 && lvl[c] && armed[c]) begin
          since[c]++;
          if (since[c] == LONG) begin
            e_long[c] = 1'b1;
            armed[c]  = 1'b0;
          end
        end
        if (s != lvl[c]) begin
          run[c]++;
          if (run[c] == DEB + 1) begin
            lvl[c] = s;
            run[c] = 0;
            if (s) begin
              e_press[c] = 1'b1; armed[c] = 1'b1; since[c] = 0;
            end else begin
              e_rel[c] = 1'b1; armed[c] = 1'b0;
            end
          end
        end else begin
          run[c] = 0;
        end
      end
      e_level[c] = lvl[c];
    end
  endtask

  task automatic chk(input string tag, input logic [KW-1:0] obs, input logic [KW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: update the model on the rising edge, compare on the falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("level",   key_level,   e_level);
    chk("press",   key_press,   e_press);
    chk("release", key_release, e_rel);
    chk("long",    key_long,    e_long);
    for (int c = 0; c < KW; c++) begin
      if (key_press[c] === 1'b1)   n_press[c]++;
      if (key_release[c] === 1'b1) n_rel[c]++;
      if (key_long[c] === 1'b1)    n_long[c]++;
    end
  endtask

  task automatic clr_counts();
    for (int c = 0; c < KW; c++) begin
      n_press[c] = 0; n_rel[c] = 0; n_long[c] = 0;
    end
  endtask

  initial begin
    int rem [KW];

    rst    = 1'b1;
    key_in = '1;
    clr_counts();
    repeat (3) step();
    chk("reset_level", key_level, '0);
    chk("reset_press", key_press, '0);
    rst = 1'b0;
    repeat (2) step();

    // Single press on key 0: pulse lands on the 7th edge after the drive (sampling edge + 6).
    clr_counts();
    key_in[0] = 1'b0;
    repeat (6) step();
    chk_int("k0_no_early_press", n_press[0], 0);
    step();
    chk("k0_press_pulse", key_press, 4'b0001);
    repeat (15) step();
    chk_int("k0_one_press", n_press[0], 1);
    chk("k0_level_held", key_level & 4'b0001, 4'b0001);

    // Short glitch on key 1 is ignored.
    clr_counts();
    key_in[1] = 1'b0;
    repeat (3) step();
    key_in[1] = 1'b1;
    repeat (15) step();
    chk_int("k1_glitch_press", n_press[1], 0);
    chk_int("k1_glitch_rel", n_rel[1], 0);
    chk("k1_glitch_level", key_level & 4'b0010, 4'b0000);

    // Key 2: short release bounce is absorbed, real release pulses once.
    clr_counts();
    key_in[2] = 1'b0;
    repeat (12) step();
    chk_int("k2_press", n_press[2], 1);
    key_in[2] = 1'b1;
    repeat (2) step();
    key_in[2] = 1'b0;
    repeat (12) step();
    chk_int("k2_bounce_no_rel", n_rel[2], 0);
    chk("k2_bounce_level", key_level & 4'b0100, 4'b0100);
    key_in[2] = 1'b1;
    repeat (12) step();
    chk_int("k2_rel_once", n_rel[2], 1);
    chk("k2_rel_level", key_level & 4'b0100, 4'b0000);

    // Release key 0, then press keys 0 and 3 together.
    key_in[0] = 1'b1;
    repeat (12) step();
    clr_counts();
    key_in[0] = 1'b0;
    key_in[3] = 1'b0;
    repeat (6) step();
    step();
    chk("k03_same_clock", key_press, 4'b1001);

    // Hold 20 more clocks: long pulse only when the feature is built in.
    repeat (20) step();
    chk_int("k0_long_count", n_long[0], LONG_EN);
    chk_int("k3_long_count", n_long[3], LONG_EN);
    key_in = '1;
    repeat (14) step();

    // Reset while key 1 is held: no release, then a fresh press after reset.
    key_in[1] = 1'b0;
    repeat (10) step();
    clr_counts();
    rst = 1'b1;
    step();
    chk("rst_level", key_level, '0);
    chk("rst_press", key_press, '0);
    chk("rst_release", key_release, '0);
    rst = 1'b0;
    repeat (6) step();
    chk_int("k1_no_early_repress", n_press[1], 0);
    step();
    chk("k1_repress", key_press, 4'b0010);
    chk_int("k1_no_rel_on_rst", n_rel[1], 0);
    key_in = '1;
    repeat (14) step();

    // Randomized traffic: mix of glitches, debounced edges, long holds and rare resets.
    for (int c = 0; c < KW; c++) rem[c] = $urandom_range(1, 8);
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      for (int c = 0; c < KW; c++) begin
        if (rem[c] == 0) begin
          key_in[c] = ~key_in[c];
          rem[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 25) : $urandom_range(1, 7);
        end else begin
          rem[c]--;
        end
      end
      step();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
